// File: rtl/mod5_pkg.sv
// mod5_pkg: types, constants and residue arithmetic for the mod-5 checked
// bit-stream link. Shared by the transmitter and the receive-side checker.
//   state_t          transmitter FSM states
//   CHK_W            width of the check field appended to every frame
//   mod5_step(r, b)  next residue after shifting bit b into a number with residue r
//   mod5_check(r)    check digit c such that (8*value + c) mod 5 == 0

package mod5_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHECK
    } state_t;

    localparam int CHK_W = 3;

    // r' = (2r + b) mod 5, written as a table so it maps to a few LUTs.
    function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
        logic [2:0] n;
        // NOTE: every path assigns n (default arm included) so no latch is implied.
        case (r)
            3'd0:    n = b ? 3'd1 : 3'd0;
            3'd1:    n = b ? 3'd3 : 3'd2;
            3'd2:    n = b ? 3'd0 : 3'd4;
            3'd3:    n = b ? 3'd2 : 3'd1;
            3'd4:    n = b ? 3'd4 : 3'd3;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Appending CHK_W bits multiplies the payload by 8 == 3 (mod 5), so the
    // check digit is c = (5 - 3r mod 5) mod 5.
    function automatic logic [2:0] mod5_check(input logic [2:0] r);
        logic [2:0] c;
        case (r)
            3'd0:    c = 3'd0;
            3'd1:    c = 3'd2;
            3'd2:    c = 3'd4;
            3'd3:    c = 3'd1;
            3'd4:    c = 3'd3;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mod5_residue.sv
// mod5_residue: running mod-5 residue of a bit stream read MSB-first.
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset (residue -> 0)
//   clr   synchronous clear, has priority over en
//   en    shift bit b into the residue this cycle
//   b     stream bit
//   r     current residue, 0..4

module mod5_residue
    import mod5_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       en,
    input  logic       b,
    output logic [2:0] r
);

    // NOTE: asynchronous active-low reset: rstn sits in the sensitivity list.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r <= 3'd0;
        end else if (clr) begin
            r <= 3'd0;
        end else if (en) begin
            // NOTE: sequential state always uses non-blocking assignment.
            r <= mod5_step(r, b);
        end
    end

endmodule

// File: rtl/mod5_serial_tx.sv
// mod5_serial_tx: accepts a DATA_W-bit payload, shifts it out MSB-first and
// appends a CHK_W-bit check field making the whole frame divisible by 5.
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   in_valid    payload on in_data is valid
//   in_data     payload word
//   in_ready    block accepts a payload this cycle (decoded, not registered)
//   err_inj     sampled at accept; flips the LSB of that frame's check field
//   dout        serial data bit
//   dout_valid  dout carries a frame bit
//   sof         first payload bit is on dout
//   eof         last check bit is on dout

module mod5_serial_tx
    import mod5_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              err_inj,
    output logic              dout,
    output logic              dout_valid,
    output logic              sof,
    output logic              eof
);

    localparam int CNT_W = $clog2((DATA_W > CHK_W) ? DATA_W : CHK_W);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_CHK  = CNT_W'(CHK_W - 1);
    localparam logic [CNT_W-1:0] PEN_CHK   = CNT_W'(CHK_W - 2);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  sreg;
    logic [CHK_W-1:0]   chk_sh;
    logic               err_q;
    logic [2:0]         res;
    logic [CHK_W-1:0]   chk_next;
    logic               last_chk;
    logic               accept;

    assign last_chk = (state == CHECK) && (cnt == LAST_CHK);
    assign in_ready = (state == IDLE) || last_chk;
    assign accept   = in_valid && in_ready;

    // The residue register lags dout by one bit, so the final residue is
    // formed here by folding in the payload bit currently on dout.
    assign chk_next = mod5_check(mod5_step(res, dout)) ^ {{(CHK_W-1){1'b0}}, err_q};

    mod5_residue u_residue (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (state == DATA),
        .b    (dout),
        .r    (res)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            chk_sh     <= '0;
            err_q      <= 1'b0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
        end else begin
            sof <= 1'b0;
            eof <= 1'b0;
            if (accept) begin
                // Accept in IDLE or back-to-back at the last check bit.
                state      <= DATA;
                cnt        <= '0;
                dout       <= in_data[DATA_W-1];
                sreg       <= in_data << 1;
                err_q      <= err_inj;
                dout_valid <= 1'b1;
                sof        <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                    end
                    DATA: begin
                        if (cnt == LAST_DATA) begin
                            state  <= CHECK;
                            cnt    <= '0;
                            dout   <= chk_next[CHK_W-1];
                            chk_sh <= chk_next << 1;
                        end else begin
                            cnt  <= cnt + 1'b1;
                            dout <= sreg[DATA_W-1];
                            sreg <= sreg << 1;
                        end
                    end
                    CHECK: begin
                        if (cnt == LAST_CHK) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            dout       <= 1'b0;
                            dout_valid <= 1'b0;
                        end else begin
                            cnt    <= cnt + 1'b1;
                            dout   <= chk_sh[CHK_W-1];
                            chk_sh <= chk_sh << 1;
                            eof    <= (cnt == PEN_CHK);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        cnt        <= '0;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod5_serial_tx.sv
// tb_mod5_serial_tx: directed and swept stimulus for mod5_serial_tx (DATA_W=8).
// The driver pushes the expected frame at accept time; a negedge monitor
// rebuilds each frame from dout and pops/compares it at eof.

module tb_mod5_serial_tx;

    localparam int DW = 8;
    localparam int FW = DW + 3;

    typedef struct {
        logic [FW-1:0] frame;
        int            res;
        int            acc_cyc;
    } exp_t;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          err_inj;
    logic          dout;
    logic          dout_valid;
    logic          sof;
    logic          eof;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    exp_t sb[$];

    mod5_serial_tx #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .err_inj    (err_inj),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sof        (sof),
        .eof        (eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent arithmetic model: choose c so that (8*d + c) mod 5 == 0.
    function automatic logic [FW-1:0] model_frame(input logic [DW-1:0] d, input logic e);
        int c;
        c = (5 - ((int'(d) * 8) % 5)) % 5;
        if (e) c = c ^ 1;
        return {d, 3'(c)};
    endfunction

    // Present a payload, wait (bounded) for in_ready, record the expectation.
    // in_valid stays high on return; the caller follows with send() or idle().
    task automatic send(input logic [DW-1:0] d, input logic e, input logic [FW-1:0] f,
                        output int acc);
        int   n;
        exp_t x;
        in_valid = 1'b1;
        in_data  = d;
        err_inj  = e;
        n        = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", n, 0);
            acc = -1;
        end else begin
            x.frame   = f;
            x.res     = int'(f) % 5;
            x.acc_cyc = cyc + 1;
            sb.push_back(x);
            @(posedge clk);
            #1;
            acc = cyc;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        err_inj  = 1'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: frame reassembly, serial reference residue, framing checks.
    logic [15:0] cur;
    int          len      = 0;
    int          sofs     = 0;
    int          rres     = 0;
    int          sof_cyc  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            cur  = '0;
            len  = 0;
            sofs = 0;
            rres = 0;
        end else begin
            check("ready_decode", {31'd0, in_ready}, {31'd0, (!dout_valid || eof)});
            if (!dout_valid) begin
                check("idle_quiet", {29'd0, dout, sof, eof}, 32'd0);
            end else begin
                if (sof) begin
                    check("sof_position", len, 0);
                    len     = 0;
                    rres    = 0;
                    sof_cyc = cyc;
                    sofs++;
                end
                cur  = {cur[14:0], dout};
                rres = (2 * rres + int'(dout)) % 5;
                len++;
                if (eof) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("frame_len", len, FW);
                        check("frame_sof_count", sofs, 1);
                        check("frame_bits", {21'd0, cur[FW-1:0]}, {21'd0, e.frame});
                        check("frame_residue", rres, e.res);
                        check("sof_latency", sof_cyc, e.acc_cyc);
                    end
                    len  = 0;
                    sofs = 0;
                end
            end
        end
    end

    logic [DW-1:0] perm [256];

    initial begin
        int acc1;
        int acc2;
        int rel;
        int n;
        logic [DW-1:0] t;

        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        err_inj  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_valid", {31'd0, dout_valid}, 0);
        check("rst_dout", {31'd0, dout}, 0);
        check("rst_sof", {31'd0, sof}, 0);
        check("rst_eof", {31'd0, eof}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // in_valid low keeps the block quiet even with garbage on in_data.
        idle(4);
        check("idle_hold_valid", {31'd0, dout_valid}, 0);
        check("idle_hold_ready", {31'd0, in_ready}, 1);

        // Directed frames with literal expected streams.
        send(8'h07, 1'b0, 11'b00000111_100, acc1);
        idle(14);
        send(8'h00, 1'b0, 11'b00000000_000, acc1);
        idle(14);
        send(8'hFF, 1'b0, 11'b11111111_000, acc1);
        idle(14);

        // Back-to-back with in_valid held high: zero gap between frames.
        send(8'h01, 1'b0, 11'b00000001_010, acc1);
        send(8'h02, 1'b0, 11'b00000010_100, acc2);
        check("b2b_spacing", acc2 - acc1, FW);
        idle(14);

        // Error injection flips the check LSB: residue 1 at end of frame.
        send(8'h07, 1'b1, 11'b00000111_101, acc1);
        idle(14);

        // Reset pulse during payload bit 4: outputs drop without a clock edge.
        send(8'h01, 1'b0, 11'b00000001_010, acc1);
        idle(3);
        rstn = 1'b0;
        #1;
        check("midrst_dout_valid", {31'd0, dout_valid}, 0);
        check("midrst_sof", {31'd0, sof}, 0);
        check("midrst_eof", {31'd0, eof}, 0);
        check("midrst_dout", {31'd0, dout}, 0);
        check("midrst_in_ready", {31'd0, in_ready}, 1);
        void'(sb.pop_back());
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_valid", {31'd0, dout_valid}, 0);
        end
        rstn = 1'b1;
        rel  = cyc;
        check("post_rst_ready", {31'd0, in_ready}, 1);
        send(8'h01, 1'b0, 11'b00000001_010, acc1);
        check("post_rst_accept", acc1, rel + 1);
        idle(14);

        // Sweep all payloads in shuffled order with mixed idle gaps.
        for (int i = 0; i < 256; i++) perm[i] = DW'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            j       = $urandom_range(0, i);
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            int gap;
            send(perm[i], 1'b0, model_frame(perm[i], 1'b0), acc1);
            gap = $urandom_range(0, 3);
            if (gap != 0) idle(gap * 5);
        end
        idle(1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
